// File: rtl/uart_framer_pkg.sv
// Shared constants and types for the UART <-> AES block framer.
package uart_framer_pkg;

   localparam int          BLOCK_BYTES          = 16;
   localparam int          BLOCK_W              = 8 * BLOCK_BYTES;
   localparam logic [23:0] DEFAULT_BYTE_TIMEOUT = 24'd500000;

   typedef enum logic [2:0] {
      T_IDLE,
      T_WAIT_RDY,
      T_START,
      T_WAIT_LOW,
      T_WAIT_HIGH
   } tx_state_t;

endpackage

// File: rtl/uart_block_serializer.sv
// TX half of the framer: takes one result block and feeds it MSB byte first
// into the UART transmitter, pacing each byte on the transmitter's ready line.
module uart_block_serializer
   import uart_framer_pkg::*;
#(
   parameter int NUM_BYTES = BLOCK_BYTES
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [8*NUM_BYTES-1:0] result_data_i,
   input  logic                   result_valid_i,
   output logic                   result_ready_o,
   input  logic                   tx_ready_i,
   output logic [7:0]             tx_data_o,
   output logic                   tx_start_o,
   output logic                   tx_busy_o
);

   localparam int BW = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES);

   tx_state_t       state_q, state_d;
   logic [BW-1:0]   shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      data_q, data_d;
   logic [1:0]      guard_q, guard_d;

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= T_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         guard_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         guard_q <= guard_d;
      end
   end

   // Next-state and handshake outputs for the byte serialiser
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      cnt_d          = cnt_q;
      data_d         = data_q;
      guard_d        = guard_q;
      result_ready_o = 1'b0;
      tx_start_o     = 1'b0;
      case (state_q)
         T_IDLE: begin
            result_ready_o = 1'b1;
            if (result_valid_i) begin
               shift_d = result_data_i;
               cnt_d   = '0;
               state_d = T_WAIT_RDY;
            end
         end
         T_WAIT_RDY: begin
            if (tx_ready_i) begin
               data_d  = shift_q[BW-1 -: 8];
               state_d = T_START;
            end
         end
         T_START: begin
            tx_start_o = 1'b1;
            guard_d    = '0;
            state_d    = T_WAIT_LOW;
         end
         T_WAIT_LOW: begin
            // A transmitter that never drops ready must not stall us forever;
            // after four cycles the byte is assumed taken.
            if (!tx_ready_i || guard_q == 2'd3) state_d = T_WAIT_HIGH;
            else                                guard_d = guard_q + 2'd1;
         end
         T_WAIT_HIGH: begin
            if (tx_ready_i) begin
               shift_d = {shift_q[BW-9:0], 8'h00};
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CW'(NUM_BYTES - 1)) ? T_IDLE : T_WAIT_RDY;
            end
         end
         default: state_d = T_IDLE;
      endcase
   end

   assign tx_data_o = data_q;
   assign tx_busy_o = (state_q != T_IDLE);

endmodule

// File: rtl/uart_block_framer.sv
// Bridges the UART byte interface and the AES core: RX bytes are packed
// MSB-first into blocks with an inter-byte timeout, TX blocks are handed to
// the serialiser.
module uart_block_framer
   import uart_framer_pkg::*;
#(
   parameter int          NUM_BYTES    = BLOCK_BYTES,
   parameter logic [23:0] BYTE_TIMEOUT = DEFAULT_BYTE_TIMEOUT
) (
   input  logic                   uart_clock,
   input  logic                   uart_reset,
   input  logic [7:0]             uart_received_data,
   input  logic                   uart_rx_valid,
   input  logic                   uart_tx_ready,
   output logic [7:0]             uart_transmit_data,
   output logic                   uart_tx_start,
   output logic [8*NUM_BYTES-1:0] block_data,
   output logic                   block_valid,
   input  logic                   block_ready,
   input  logic [8*NUM_BYTES-1:0] result_data,
   input  logic                   result_valid,
   output logic                   result_ready,
   output logic                   rx_overrun,
   output logic                   tx_busy
);

   localparam int BW = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES);

   logic          rx_valid_q;
   logic [BW-1:0] rx_shift_q, rx_shift_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, rx_base;
   logic [23:0]   idle_q, idle_d;
   logic [BW-1:0] blk_data_q, blk_data_d;
   logic          blk_valid_q, blk_valid_d;
   logic          overrun_q, overrun_d;
   logic          rx_take, timeout_fire, blk_done;

   // RX and output-register state
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         rx_valid_q  <= 1'b0;
         rx_shift_q  <= '0;
         rx_cnt_q    <= '0;
         idle_q      <= '0;
         blk_data_q  <= '0;
         blk_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_valid_q  <= uart_rx_valid;
         rx_shift_q  <= rx_shift_d;
         rx_cnt_q    <= rx_cnt_d;
         idle_q      <= idle_d;
         blk_data_q  <= blk_data_d;
         blk_valid_q <= blk_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Byte capture on rx_valid rising edge, assembly, and inter-byte timeout
   always_comb begin
      rx_take      = uart_rx_valid & ~rx_valid_q;
      timeout_fire = (BYTE_TIMEOUT != 24'd0) && (rx_cnt_q != '0) && (idle_q == BYTE_TIMEOUT);
      // A timeout restarts the block; a byte landing on the same cycle is byte 0.
      rx_base      = timeout_fire ? '0 : rx_cnt_q;
      rx_shift_d   = rx_shift_q;
      rx_cnt_d     = rx_base;
      blk_done     = 1'b0;
      if (rx_take) begin
         rx_shift_d = {rx_shift_q[BW-9:0], uart_received_data};
         if (rx_base == CW'(NUM_BYTES - 1)) begin
            rx_cnt_d = '0;
            blk_done = 1'b1;
         end else begin
            rx_cnt_d = rx_base + 1'b1;
         end
      end
      if (rx_take || timeout_fire || BYTE_TIMEOUT == 24'd0 || rx_cnt_q == '0) idle_d = '0;
      else                                                                    idle_d = idle_q + 24'd1;
   end

   // Block output register: hold until accepted, drop and flag on overrun
   always_comb begin
      blk_data_d  = blk_data_q;
      blk_valid_d = blk_valid_q;
      overrun_d   = overrun_q;
      if (blk_done) begin
         if (blk_valid_q && !block_ready) begin
            overrun_d = 1'b1;
         end else begin
            blk_data_d  = rx_shift_d;
            blk_valid_d = 1'b1;
         end
      end else if (blk_valid_q && block_ready) begin
         blk_valid_d = 1'b0;
      end
   end

   assign block_data  = blk_data_q;
   assign block_valid = blk_valid_q;
   assign rx_overrun  = overrun_q;

   uart_block_serializer #(
      .NUM_BYTES (NUM_BYTES)
   ) u_ser (
      .clk_i          (uart_clock),
      .rst_ni         (uart_reset),
      .result_data_i  (result_data),
      .result_valid_i (result_valid),
      .result_ready_o (result_ready),
      .tx_ready_i     (uart_tx_ready),
      .tx_data_o      (uart_transmit_data),
      .tx_start_o     (uart_tx_start),
      .tx_busy_o      (tx_busy)
   );

endmodule

// File: tb/tb_uart_block_framer.sv
// Bench for uart_block_framer: directed stimulus, queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_uart_block_framer;

   localparam int TO = 100;

   logic         uart_clock = 1'b0;
   logic         uart_reset = 1'b0;
   logic [7:0]   uart_received_data = '0;
   logic         uart_rx_valid = 1'b0;
   logic         uart_tx_ready = 1'b1;
   logic [7:0]   uart_transmit_data;
   logic         uart_tx_start;
   logic [127:0] block_data;
   logic         block_valid;
   logic         block_ready = 1'b0;
   logic [127:0] result_data = '0;
   logic         result_valid = 1'b0;
   logic         result_ready;
   logic         rx_overrun;
   logic         tx_busy;

   int n_chk  = 0;
   int n_fail = 0;

   uart_block_framer #(
      .NUM_BYTES    (16),
      .BYTE_TIMEOUT (24'd100)
   ) dut (
      .uart_clock         (uart_clock),
      .uart_reset         (uart_reset),
      .uart_received_data (uart_received_data),
      .uart_rx_valid      (uart_rx_valid),
      .uart_tx_ready      (uart_tx_ready),
      .uart_transmit_data (uart_transmit_data),
      .uart_tx_start      (uart_tx_start),
      .block_data         (block_data),
      .block_valid        (block_valid),
      .block_ready        (block_ready),
      .result_data        (result_data),
      .result_valid       (result_valid),
      .result_ready       (result_ready),
      .rx_overrun         (rx_overrun),
      .tx_busy            (tx_busy)
   );

   always #5 uart_clock = ~uart_clock;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transmitter model: drops ready for 10 cycles after each start pulse
   int low_cnt = 0;
   always @(negedge uart_clock) begin
      if (uart_tx_start) begin
         low_cnt = 10;
         uart_tx_ready = 1'b0;
      end else if (low_cnt > 0) begin
         low_cnt--;
         if (low_cnt == 0) uart_tx_ready = 1'b1;
      end
   end

   // Reference model state
   logic [7:0]   m_part[$];
   logic [7:0]   exp_q[$];
   logic [7:0]   tx_log[$];
   logic         m_valid = 1'b0, m_ovr = 1'b0, m_prev = 1'b0, prev_start = 1'b0;
   logic [127:0] m_data = '0, blk, cap_data = '0;
   int           m_cyc = 0, m_last = 0, bv_cycles = 0, tx_starts = 0;
   logic         byte_now;

   // Compare DUT against model, then advance model with the inputs of the coming edge
   always @(negedge uart_clock) begin
      if (!uart_reset) begin
         chk("rst_block_valid", block_valid, 0);
         chk("rst_tx_start", uart_tx_start, 0);
         chk("rst_tx_busy", tx_busy, 0);
         chk("rst_overrun", rx_overrun, 0);
         m_valid = 0; m_ovr = 0; m_prev = 0; prev_start = 0;
         m_part.delete(); exp_q.delete();
      end else begin
         chk("blk_valid", block_valid, m_valid);
         if (m_valid) chk("blk_data", block_data, m_data);
         chk("overrun", rx_overrun, m_ovr);
         if (block_valid) begin bv_cycles++; cap_data = block_data; end
         if (uart_tx_start) begin
            tx_starts++;
            tx_log.push_back(uart_transmit_data);
            chk("start_one_cycle", prev_start, 0);
            if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
            else chk("tx_byte", uart_transmit_data, exp_q.pop_front());
         end
         if (exp_q.size() != 0) chk("result_ready_busy", result_ready, 0);
         prev_start = uart_tx_start;
         // model update
         m_cyc++;
         byte_now = uart_rx_valid && !m_prev;
         m_prev = uart_rx_valid;
         if (byte_now) begin
            if (m_part.size() != 0 && (m_cyc - m_last) > TO) m_part.delete();
            m_last = m_cyc;
            m_part.push_back(uart_received_data);
         end
         if (byte_now && m_part.size() == 16) begin
            blk = '0;
            for (int i = 0; i < 16; i++) blk = {blk[119:0], m_part[i]};
            m_part.delete();
            if (m_valid && !block_ready) m_ovr = 1;
            else begin m_valid = 1; m_data = blk; end
         end else if (m_valid && block_ready) begin
            m_valid = 0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge uart_clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      uart_received_data = b;
      uart_rx_valid = 1'b1;
      cyc(hold);
      uart_rx_valid = 1'b0;
      cyc(gap);
   endtask

   task automatic present(input logic [127:0] r);
      chk("result_ready_idle", result_ready, 1);
      result_data = r;
      result_valid = 1'b1;
      cyc(1);
      result_valid = 1'b0;
      for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
   endtask

   task automatic wait_starts(input int target, input string nm);
      int k = 0;
      while (tx_starts < target && k < 2000) begin cyc(1); k++; end
      chk(nm, tx_starts, target);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (tx_busy && k < 60) begin cyc(1); k++; end
      chk(nm, tx_busy, 0);
   endtask

   int bv0, s0;

   initial begin
      cyc(3);
      chk("rst_data", block_data, 0);
      chk("rst_txdata", uart_transmit_data, 0);
      uart_reset = 1'b1;
      block_ready = 1'b1;
      cyc(1);

      // 1: bytes 00..0F
      bv0 = bv_cycles;
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 2);
      cyc(4);
      chk("t1_pulses", bv_cycles - bv0, 1);
      chk("t1_data", cap_data, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t1_overrun", rx_overrun, 0);

      // 2: long-held rx_valid gives one byte per edge
      bv0 = bv_cycles;
      for (int i = 0; i < 16; i++) send_byte(8'hAA, 50, 2);
      cyc(4);
      chk("t2_pulses", bv_cycles - bv0, 1);
      chk("t2_data", cap_data, {16{8'hAA}});

      // 3: partial block discarded by timeout
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1, 2);
      cyc(150);
      bv0 = bv_cycles;
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1, 2);
      cyc(4);
      chk("t3_pulses", bv_cycles - bv0, 1);
      chk("t3_data", cap_data, 128'h101112131415161718191A1B1C1D1E1F);

      // 4: overrun while block held
      block_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 2);
      for (int i = 0; i < 16; i++) send_byte(8'hFF, 1, 2);
      cyc(4);
      chk("t4_valid_held", block_valid, 1);
      chk("t4_data_kept", block_data, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t4_overrun", rx_overrun, 1);
      block_ready = 1'b1;
      cyc(1);
      chk("t4_valid_fall", block_valid, 0);

      // 5: transmit one result
      tx_log.delete();
      s0 = tx_starts;
      present(128'h3AD77BB40D7A3660A89ECAF32466EF97);
      wait_starts(s0 + 16, "t5_starts");
      chk("t5_log_n", tx_log.size(), 16);
      if (tx_log.size() >= 16) begin
         chk("t5_first", tx_log[0], 8'h3A);
         chk("t5_second", tx_log[1], 8'hD7);
         chk("t5_last", tx_log[15], 8'h97);
      end
      wait_idle("t5_busy_fall");
      chk("t5_ready_back", result_ready, 1);
      chk("t5_all_sent", exp_q.size(), 0);

      // 6: reset mid-transmit, then a fresh result starts from byte 0
      s0 = tx_starts;
      present(128'h00112233445566778899AABBCCDDEEFF);
      wait_starts(s0 + 8, "t6_partial");
      cyc(3);
      uart_reset = 1'b0;
      #1;
      chk("t6_rst_start", uart_tx_start, 0);
      chk("t6_rst_busy", tx_busy, 0);
      cyc(2);
      uart_reset = 1'b1;
      cyc(1);
      chk("t6_busy", tx_busy, 0);
      chk("t6_start", uart_tx_start, 0);
      tx_log.delete();
      s0 = tx_starts;
      present(128'hC0FFEE0123456789ABCDEF0011223344);
      wait_starts(s0 + 16, "t6_starts");
      if (tx_log.size() >= 16) begin
         chk("t6_first", tx_log[0], 8'hC0);
         chk("t6_last", tx_log[15], 8'h44);
      end else chk("t6_log_n", tx_log.size(), 16);
      wait_idle("t6_busy_fall");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
